uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Serial-to-byte receive front end for the user-project UART. It samples the `rx` pad input (mprj_io_5), validates start and stop bits, and assembles 8-bit LSB-first frames. Each good byte is presented with a one-cycle `rx_valid` pulse that drives the rx FIFO write enable and the interrupt/byte counters downstream. It runs in the Wishbone clock domain and takes its bit period from the top-level `clk_div`, which is 40 MHz / BAUD_RATE.

## Interface
- `MIN_CLK_DIV`, default 4: smallest honoured bit period in clocks; smaller `clk_div` values are clamped up to this.
- `clk`  in  1: Wishbone clock (`wb_clk_i`).
- `rst_n`  in  1: reset, synchronous and active-low.
- `clk_div`  in  32: clocks per bit; latched at frame start.
- `rx`  in  1: asynchronous serial line; idle high.
- `rx_data`  out  8: last good byte; reset 0x00; changes only with `rx_valid`.
- `rx_valid`  out  1: one-cycle pulse per good frame; reset 0.
- `frame_err`  out  1: level; set on bad stop bit, cleared on next good frame; reset 0.
- `busy`  out  1: high while a frame is in progress (states other than IDLE); reset 0.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- **States.**
  - IDLE: a low `rx_s` goes to START. Call this detection cycle D. In D, latch `div = max(clk_div, MIN_CLK_DIV)` and `half = div >> 1`, and clear the baud counter.
  - START: at D+half, sample `rx_s`. If high, the frame was a glitch: return to IDLE with no output change. If low, go to DATA with the bit index at 0.
  - DATA: sample bit i at D+half+(i+1)*div, i = 0..7, shifting LSB-first into the shift register. After bit 7, go to STOP.
  - STOP: sample at D+half+9*div.
    - High: register `rx_data` from the shift register, pulse `rx_valid`, clear `frame_err`, go to IDLE.
    - Low: set `frame_err`, no `rx_valid`, go to REARM.
  - REARM: wait for `rx_s` = 1, then go to IDLE. This prevents a break condition from retriggering endlessly.
- **Counters.**
  - Baud counter is 32 bits, compares against `half-1` or `div-1`, and wraps to 0 at each sample point.
  - Bit index is 3 bits.
  - The latched `div` holds for the whole frame. Changes on `clk_div` mid-frame take effect at the next frame.
- **Back-to-back frames.** A new start may be detected in the first cycle after returning to IDLE. There is no dead time beyond the one IDLE cycle.
- **Reset.** Reset at any time, including mid-frame, returns to IDLE. All outputs go to their reset values, the synchronizer goes to 1, and no partial byte is emitted.

## Timing
- Pad to `rx_s` latency is 2 clocks. D is the first IDLE cycle in which `rx_s` is 0.
- `rx_valid` and the new `rx_data` are high/valid in cycle D+half+9*div+1 (registered outputs).
- `frame_err` updates in the same cycle that `rx_valid` would have pulsed.
- `busy` is high from D+1 through the last STOP or REARM cycle, and low again in the cycle after.
- A minimum of one IDLE cycle separates consecutive frames.
- `rx_valid` is never high for two consecutive cycles.

## Structure
- Shared package `uart_pkg`:
  - State encoding: IDLE, START, DATA, STOP, REARM, 3-bit.
  - `MIN_CLK_DIV` default.
  - `UART_DATA_W` = 8.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset-to-1. Reused later for CTS.
- The top is a single FSM with the baud counter, bit index and shift register. Target size is about 150–200 lines.

## Test plan
All scenarios use `clk_div` = 16 (`half` = 8) unless noted.
- **Single byte.** Drive 0xA5 with a good stop bit → exactly one `rx_valid` at D+153, `rx_data` = 0xA5, `frame_err` = 0, `busy` low at D+154.
- **Glitch.** Low pulse of 3 clocks on an idle line → no `rx_valid`; `busy` high for about 8 cycles then 0; `rx_data` unchanged.
- **Frame error and recovery.** Drive 0x00 with the stop bit low, then hold the line low for 40 bit-times, then release. Result: `frame_err` = 1, no `rx_valid`, no new frame while the line is low. A following 0x3C gives `rx_valid`, `rx_data` = 0x3C, `frame_err` = 0.
- **Back-to-back.** Drive 0x01 then 0xFF, each with a 1-bit stop and no idle gap → two `rx_valid` pulses 160 ± 1 clocks apart; data 0x01 then 0xFF. Repeat 9 frames to exercise FIFO-full upstream counting.
- **Divider change and clamp.**
  - Change `clk_div` 16→32 at D+50 → the current frame is still decoded at 16.
  - The next frame at 32 decodes correctly.
  - `clk_div` = 1 behaves as 4.
- **Reset mid-frame.** Assert `rst_n` = 0 for one clock during DATA bit 3 → all outputs 0 on the next edge; no `rx_valid` for that frame; the next full frame decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, data width and the
// smallest bit period the receiver will honour.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_MIN_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_REARM = 3'd4
    } rx_state_t;

    // Bit periods below min_div cannot place a mid-bit sample, so raise them.
    function automatic logic [31:0] clamp_div(input logic [31:0] div,
                                              input logic [31:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous line; both stages
// reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx, checks start/stop bits and
// assembles LSB-first bytes, emitting a one-cycle rx_valid per good frame.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned MIN_CLK_DIV = UART_MIN_CLK_DIV
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            clk_div,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   busy,
    output rx_state_t              o_dbg_state
);

    // Handshake: rx_valid is a single-cycle strobe with no backpressure;
    // rx_data is valid in that cycle and holds until the next strobe.

    logic                   w_rx_s;
    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic [31:0]            r_div;
    logic [31:0]            r_half;
    logic [31:0]            r_cnt;
    logic [2:0]             r_bit_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    logic [31:0]            w_div_clamped;
    logic                   w_half_hit;
    logic                   w_full_hit;
    logic                   w_load;
    logic                   w_sample;
    logic                   w_start_ok;
    logic                   w_shift;
    logic                   w_good;
    logic                   w_bad;
    logic                   w_cnt_run;

    uart_rx_sync u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    assign w_div_clamped = clamp_div(clk_div, 32'(MIN_CLK_DIV));
    assign w_half_hit    = (r_cnt == r_half - 32'd1);
    assign w_full_hit    = (r_cnt == r_div - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_start_ok  = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        w_cnt_run   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                    w_load      = 1'b1;
                end
            end
            ST_START: begin
                w_cnt_run = 1'b1;
                if (w_half_hit) begin
                    w_sample = 1'b1;
                    if (w_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_start_ok  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                w_cnt_run = 1'b1;
                if (w_full_hit) begin
                    w_sample = 1'b1;
                    w_shift  = 1'b1;
                    if (r_bit_idx == 3'(UART_DATA_W - 1)) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                w_cnt_run = 1'b1;
                if (w_full_hit) begin
                    w_sample = 1'b1;
                    if (w_rx_s) begin
                        w_good      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = ST_REARM;
                    end
                end
            end
            ST_REARM: begin
                // A held-low line (break) must go high before a new start counts.
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div       <= 32'(MIN_CLK_DIV);
            r_half      <= 32'(MIN_CLK_DIV) >> 1;
            r_cnt       <= 32'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_load) begin
                r_div  <= w_div_clamped;
                r_half <= w_div_clamped >> 1;
                r_cnt  <= 32'd0;
            end else if (w_sample) begin
                r_cnt <= 32'd0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_start_ok) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
            end
            if (w_good) begin
                r_rx_data   <= r_shift;
                r_rx_valid  <= 1'b1;
                r_frame_err <= 1'b0;
            end else if (w_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: a serial driver pushes the
// expected byte and arrival cycle, a monitor pops and compares on rx_valid.
module tb_uart_rx_deserializer;
    import uart_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [31:0]     clk_div;
    logic            rx;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            frame_err;
    logic            busy;
    rx_state_t       dbg_state;

    logic [7:0]      exp_q[$];
    logic [31:0]     exp_t_q[$];
    int              checks;
    int              errors;
    logic [31:0]     cyc;
    logic            prev_valid;

    uart_rx_deserializer #(.MIN_CLK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_div     (clk_div),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter model: one frame at the clamped bit period; good frames
    // schedule the byte for D + half + 9*div + 1, D being 2 clocks after the pad edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int unsigned eff;
        logic [31:0] c;
        eff = (clk_div < 32'd4) ? 4 : clk_div;
        @(negedge clk);
        rx = 1'b0;
        c = cyc;
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_t_q.push_back(c + 32'd2 + 32'(eff / 2) + 32'(9 * eff) + 32'd1);
        end
        repeat (eff - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (eff - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop_ok;
        repeat (eff - 1) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_pulse: rx_valid high two cycles, expected single pulse (cycle %0d)", cyc);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rx_valid data 0x%0h, expected none (cycle %0d)", rx_data, cyc);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                check("valid_cycle", cyc, exp_t_q.pop_front());
                check("frame_err_at_valid", 32'(frame_err), 32'd0);
            end
        end
        prev_valid = rx_valid;
    end

    initial begin
        logic [7:0] held;
        checks     = 0;
        errors     = 0;
        prev_valid = 1'b0;
        rst_n      = 1'b0;
        rx         = 1'b1;
        clk_div    = 32'd16;
        repeat (4) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with busy window
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (155) @(negedge clk);
                check("busy_in_stop", 32'(busy), 32'd1);
                repeat (2) @(negedge clk);
                check("busy_after_frame", 32'(busy), 32'd0);
            end
        join
        repeat (10) @(negedge clk);

        // Glitch: 3-clock low pulse
        held = rx_data;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'd1);
        repeat (6) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_data_held", 32'(rx_data), 32'(held));
        repeat (10) @(negedge clk);

        // Frame error, break hold, recovery
        send_frame(8'h00, 1'b0);
        check("frame_err_set", 32'(frame_err), 32'd1);
        repeat (640) @(negedge clk);
        check("break_frame_err", 32'(frame_err), 32'd1);
        check("break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rearm_idle", 32'(busy), 32'd0);
        check("err_held_until_good", 32'(frame_err), 32'd1);
        send_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        check("frame_err_cleared", 32'(frame_err), 32'd0);

        // Back-to-back: fixed pair then random bytes, no idle gap
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        repeat (20) @(negedge clk);

        // Divider change mid-frame, then next frame at 32, then clamp
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (53) @(negedge clk);
                clk_div = 32'd32;
            end
        join
        repeat (10) @(negedge clk);
        send_frame(8'h5E, 1'b1);
        repeat (10) @(negedge clk);
        clk_div = 32'd1;
        send_frame(8'h6B, 1'b1);
        repeat (10) @(negedge clk);

        // Random divisors, including clamped ones
        for (int i = 0; i < 4; i++) begin
            clk_div = (i % 2 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(4, 24));
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        clk_div = 32'd16;
        repeat (10) @(negedge clk);

        // Reset during DATA bit 3
        @(negedge clk);
        rx = 1'b0;
        repeat (66) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx    = 1'b1;
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        repeat (200) @(negedge clk);
        send_frame(8'h96, 1'b1);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
